excess3_to_bcd_serial: RTL and testbench

EXCESS3_TO_BCD_SERIAL -- requirements
Module: excess3_to_bcd_serial

---
 rtl/excess3_to_bcd_serial.sv | 116 +++++++++++
 tb/tb_excess3_to_bcd_serial.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/excess3_to_bcd_serial.sv
// Bit-serial Excess-3 to BCD converter: subtracts 0011 from each LSB-first nibble,
// streams the difference bits out and presents each completed digit in parallel.
module excess3_to_bcd_serial (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       bit_vld,
  input  logic       sync,
  output logic       bit_out,
  output logic       bit_out_vld,
  output logic [3:0] dat_out,
  output logic       dat_vld,
  output logic       err
);

  typedef enum logic [2:0] {
    P0,
    P1_B0,
    P1_B1,
    P2_B0,
    P2_B1,
    P3_B0,
    P3_B1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] sreg_q, sreg_d;
  logic       bit_out_q, bit_out_d;
  logic       bit_out_vld_q, bit_out_vld_d;
  logic [3:0] dat_out_q, dat_out_d;
  logic       dat_vld_q, dat_vld_d;
  logic       err_q, err_d;

  logic [1:0] pos;
  logic       brw;
  logic       sub;
  logic       diff;
  logic       brw_nxt;
  logic [3:0] digit;

  always_comb begin
    pos = 2'd0;
    brw = 1'b0;
    case (state_q)
      P1_B0:   begin pos = 2'd1; brw = 1'b0; end
      P1_B1:   begin pos = 2'd1; brw = 1'b1; end
      P2_B0:   begin pos = 2'd2; brw = 1'b0; end
      P2_B1:   begin pos = 2'd2; brw = 1'b1; end
      P3_B0:   begin pos = 2'd3; brw = 1'b0; end
      P3_B1:   begin pos = 2'd3; brw = 1'b1; end
      default: begin pos = 2'd0; brw = 1'b0; end
    endcase
    // sync realigns the bit being accepted this cycle to a fresh nibble
    if (sync) begin
      pos = 2'd0;
      brw = 1'b0;
    end

    sub     = ~pos[1];
    diff    = bit_in ^ sub ^ brw;
    brw_nxt = (~bit_in & (sub | brw)) | (sub & brw);
    digit   = {diff, sreg_q[3:1]};

    state_d       = sync ? P0 : state_q;
    sreg_d        = sreg_q;
    bit_out_d     = bit_out_q;
    bit_out_vld_d = 1'b0;
    dat_out_d     = dat_out_q;
    dat_vld_d     = 1'b0;
    err_d         = err_q;

    if (bit_vld) begin
      bit_out_d     = diff;
      bit_out_vld_d = 1'b1;
      sreg_d        = digit;
      case (pos)
        2'd0: state_d = brw_nxt ? P1_B1 : P1_B0;
        2'd1: state_d = brw_nxt ? P2_B1 : P2_B0;
        2'd2: state_d = brw_nxt ? P3_B1 : P3_B0;
        default: begin
          state_d   = P0;
          dat_out_d = digit;
          dat_vld_d = 1'b1;
          err_d     = brw_nxt | (digit > 4'd9);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= P0;
      sreg_q        <= '0;
      bit_out_q     <= 1'b0;
      bit_out_vld_q <= 1'b0;
      dat_out_q     <= '0;
      dat_vld_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sreg_q        <= sreg_d;
      bit_out_q     <= bit_out_d;
      bit_out_vld_q <= bit_out_vld_d;
      dat_out_q     <= dat_out_d;
      dat_vld_q     <= dat_vld_d;
      err_q         <= err_d;
    end
  end

  assign bit_out     = bit_out_q;
  assign bit_out_vld = bit_out_vld_q;
  assign dat_out     = dat_out_q;
  assign dat_vld     = dat_vld_q;
  assign err         = err_q;

endmodule

// File: tb/tb_excess3_to_bcd_serial.sv
// Directed bench for excess3_to_bcd_serial: an arithmetic model (code - 3) checked every
// cycle, plus literal expectations on the captured digit and bit streams per scenario.
module tb_excess3_to_bcd_serial;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic       bit_vld;
  logic       sync;
  logic       bit_out;
  logic       bit_out_vld;
  logic [3:0] dat_out;
  logic       dat_vld;
  logic       err;

  int checks = 0;
  int errors = 0;

  int         m_pos;
  int         m_code;
  logic       e_bit_out;
  logic       e_bit_out_vld;
  logic [3:0] e_dat_out;
  logic       e_dat_vld;
  logic       e_err;

  logic       bq[$];
  logic [3:0] dq[$];
  logic       eq[$];

  excess3_to_bcd_serial dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_in      (bit_in),
    .bit_vld     (bit_vld),
    .sync        (sync),
    .bit_out     (bit_out),
    .bit_out_vld (bit_out_vld),
    .dat_out     (dat_out),
    .dat_vld     (dat_vld),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: bit i of the output is bit i of (low i+1 code bits - 3); digit is code - 3.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos         = 0;
      m_code        = 0;
      e_bit_out     = 1'b0;
      e_bit_out_vld = 1'b0;
      e_dat_out     = 4'd0;
      e_dat_vld     = 1'b0;
      e_err         = 1'b0;
    end else begin
      e_bit_out_vld = 1'b0;
      e_dat_vld     = 1'b0;
      if (sync) m_pos = 0;
      if (bit_vld) begin
        if (m_pos == 0) m_code = int'(bit_in);
        else m_code = m_code | (int'(bit_in) << m_pos);
        e_bit_out     = 1'(((m_code & ((1 << (m_pos + 1)) - 1)) - 3) >> m_pos);
        e_bit_out_vld = 1'b1;
        if (m_pos == 3) begin
          e_dat_out = 4'(m_code - 3);
          e_dat_vld = 1'b1;
          e_err     = (m_code < 3) || (m_code > 12);
          m_pos     = 0;
        end else begin
          m_pos++;
        end
      end
      #1;
      chk("bit_out_vld", int'(bit_out_vld), int'(e_bit_out_vld));
      if (e_bit_out_vld) chk("bit_out", int'(bit_out), int'(e_bit_out));
      chk("dat_vld", int'(dat_vld), int'(e_dat_vld));
      chk("dat_out", int'(dat_out), int'(e_dat_out));
      chk("err", int'(err), int'(e_err));
      if (bit_out_vld) bq.push_back(bit_out);
      if (dat_vld) begin
        dq.push_back(dat_out);
        eq.push_back(err);
      end
    end
  end

  task automatic drive(input logic b, input logic v, input logic s);
    @(negedge clk);
    bit_in  = b;
    bit_vld = v;
    sync    = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_code(input logic [3:0] code, input int gap);
    for (int i = 0; i < 4; i++) begin
      drive(code[i], 1'b1, 1'b0);
      if (i < 3) idle(gap);
    end
  endtask

  task automatic flush();
    idle(3);
    bq.delete();
    dq.delete();
    eq.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bit_out"}, int'(bit_out), 0);
    chk({tag, "_bit_out_vld"}, int'(bit_out_vld), 0);
    chk({tag, "_dat_out"}, int'(dat_out), 0);
    chk({tag, "_dat_vld"}, int'(dat_vld), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    rst_n   = 1'b1;
    bit_in  = 1'b0;
    bit_vld = 1'b0;
    sync    = 1'b0;
    #1 rst_n = 1'b0;
    #2 chk_reset_vals("rst0");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    flush();

    // 0111 -> 0100, serial 0,0,1,0
    send_code(4'b0111, 0);
    idle(2);
    chk("s1_bits", int'(bq.size()), 4);
    if (bq.size() == 4) begin
      chk("s1_b0", int'(bq[0]), 0);
      chk("s1_b1", int'(bq[1]), 0);
      chk("s1_b2", int'(bq[2]), 1);
      chk("s1_b3", int'(bq[3]), 0);
    end
    chk("s1_ndig", int'(dq.size()), 1);
    if (dq.size() == 1) begin
      chk("s1_dig", int'(dq[0]), 4);
      chk("s1_err", int'(eq[0]), 0);
    end
    flush();

    // all valid codes back-to-back
    for (int c = 3; c <= 12; c++) send_code(4'(c), 0);
    idle(2);
    chk("s2_ndig", int'(dq.size()), 10);
    if (dq.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        chk("s2_dig", int'(dq[i]), i);
        chk("s2_err", int'(eq[i]), 0);
      end
    end
    flush();

    // invalid codes, then recovery
    send_code(4'b0010, 0);
    send_code(4'b1101, 0);
    send_code(4'b0011, 0);
    idle(2);
    chk("s3_ndig", int'(dq.size()), 3);
    if (dq.size() == 3) begin
      chk("s3_dig0", int'(dq[0]), 15);
      chk("s3_err0", int'(eq[0]), 1);
      chk("s3_dig1", int'(dq[1]), 10);
      chk("s3_err1", int'(eq[1]), 1);
      chk("s3_dig2", int'(dq[2]), 0);
      chk("s3_err2", int'(eq[2]), 0);
    end
    flush();

    // 1100 with 3-cycle gaps between bits
    send_code(4'b1100, 3);
    idle(2);
    chk("s4_bits", int'(bq.size()), 4);
    chk("s4_ndig", int'(dq.size()), 1);
    if (dq.size() == 1) chk("s4_dig", int'(dq[0]), 9);
    flush();

    // two bits, then sync with 0101
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    idle(2);
    chk("s5_ndig", int'(dq.size()), 1);
    if (dq.size() == 1) chk("s5_dig", int'(dq[0]), 2);
    flush();

    // reset mid-nibble, then 1000
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    bit_vld = 1'b0;
    #3;
    chk("s6_pre_bit_out", int'(bit_out), 1);
    rst_n = 1'b0;
    #1 chk_reset_vals("s6_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_code(4'b1000, 0);
    idle(2);
    chk("s6_ndig", int'(dq.size()), 1);
    if (dq.size() == 1) chk("s6_dig", int'(dq[0]), 5);
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
